regfile_sequencer: RTL
======================

Name: regfile_sequencer

Overview:
- Control FSM that drives the write and read sides of the 8x16 register file (writenum/write/readnum) and the datapath load enables.
- Accepts one 16-bit instruction per start handshake, sequences the register reads into A/B, sequences the ALU step, and writes the result back.
- Sits between the instruction source (switches or instruction register) and the datapath/regfile.

Parameters:
- RN_W, 3, register-number width; must match the regfile address width.
- IW, 16, instruction width. Fixed; the field positions below assume 16.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- s  in  1  start; sampled only in IDLE
- in_instr  in  IW  instruction; captured on the start edge
- w  out  1  ready/idle indicator; 1 only in IDLE
- err  out  1  one-cycle pulse on an illegal opcode
- readnum  out  RN_W  regfile read select
- writenum  out  RN_W  regfile write select
- write  out  1  regfile write enable
- loada, loadb, loadc, loads  out  1 each  datapath register enables
- asel, bsel  out  1 each  ALU source selects
- vsel  out  2  writeback mux select: 00=C, 10=sximm8
- sximm8  out  16  sign-extended instr[7:0] of the latched instruction

Behaviour:
- Interface: one clock, clk; reset_n is asynchronous, active-low.
- Reset:
  - state=IDLE, instruction latch=0.
  - All outputs are 0 except w=1; vsel=00.
  - Reset asserted mid-sequence aborts immediately: write drops without waiting for a clock, and the partial operation is discarded.
- Instruction fields (from the latched copy):
  - opcode = [15:13], op = [12:11], Rn = [10:8], Rd = [7:5], Rm = [2:0].
- Outputs are Moore (decoded from state only). Unlisted outputs are 0 in each state.
- States and transitions:
  - IDLE:
    - w=1.
    - If s=1, latch in_instr and go to DECODE.
    - in_instr changes while not in IDLE have no effect.
  - DECODE (branch only):
    - 110/10 (MOV imm) -> WR_IMM
    - 110/00 (MOV reg) -> RD_B
    - 101/00 ADD, 101/01 CMP, 101/10 AND -> RD_A
    - 101/11 (MVN) -> RD_B
    - anything else -> ERR
  - RD_A: readnum=Rn, loada=1 -> RD_B.
  - RD_B: readnum=Rm, loadb=1 -> EXEC.
  - EXEC:
    - asel = 1 for MOV reg and MVN, else 0; bsel=0.
    - CMP: loads=1, loadc=0 -> IDLE.
    - All others: loadc=1 -> WR_C.
  - WR_C: writenum=Rd, vsel=00, write=1 -> IDLE.
  - WR_IMM: writenum=Rn, vsel=10, write=1 -> IDLE.
  - ERR: err=1 for exactly one cycle -> IDLE. No write and no load.
- Latency, counted from the clock edge that samples s=1 (edge 0) until w returns to 1:
  - MOV imm: 3 edges.
  - MOV reg / MVN: 5 edges.
  - ADD / AND: 6 edges.
  - CMP: 5 edges.
  - Illegal: 3 edges.
- s held high continuously:
  - A new instruction starts on the first edge in IDLE.
  - There is exactly one IDLE cycle (w=1) between back-to-back instructions.
- At most one write pulse per instruction; write is never asserted outside WR_C and WR_IMM.
- readnum = 0 in every state other than RD_A and RD_B. writenum = 0 when write=0.
- sximm8 is valid from DECODE until the next capture.

Test Plan:
- Reset: reset_n=0 asynchronously while in EXEC of ADD -> w=1, write=0, all loads 0 before the next clk edge; after release, s=0 keeps IDLE.
- MOV imm: in_instr=16'hD207 (MOV R2,#7), s=1 -> DECODE, then WR_IMM with writenum=2, vsel=10, write=1, sximm8=16'h0007; w=1 on the 3rd edge.
- Sign extension: in_instr=16'hD1F0 (MOV R1,#-16) -> sximm8=16'hFFF0, writenum=1.
- ADD: in_instr=16'hA161 (Rn=1, Rd=3, Rm=1) -> RD_A readnum=1 loada=1; RD_B readnum=1 loadb=1; EXEC loadc=1 asel=0; WR_C writenum=3 write=1 vsel=00.
- CMP: 16'hA902 -> loads=1 in EXEC, no write at any cycle, returns to IDLE after 5 edges. MVN: 16'hB8E5 -> RD_B readnum=5, EXEC asel=1, WR_C writenum=7.
- Illegal and back-to-back: in_instr=16'h0000 -> err pulse of one cycle, no write. Then s held high with two MOV imm instructions -> exactly one w=1 cycle between them, and the second in_instr is captured only in IDLE.

Source files
------------

// File: rtl/regfile_sequencer_if.sv
// regfile_sequencer_if: instruction handshake plus regfile/datapath control bundle.
interface regfile_sequencer_if #(
  parameter int RN_W = 3,
  parameter int IW   = 16
);
  logic            s;
  logic [IW-1:0]   in_instr;
  logic            w;
  logic            err;
  logic [RN_W-1:0] readnum;
  logic [RN_W-1:0] writenum;
  logic            write;
  logic            loada;
  logic            loadb;
  logic            loadc;
  logic            loads;
  logic            asel;
  logic            bsel;
  logic [1:0]      vsel;
  logic [15:0]     sximm8;
  modport slave (
    input  s, in_instr,
    output w, err, readnum, writenum, write, loada, loadb, loadc, loads, asel, bsel, vsel, sximm8
  );
  modport master (
    output s, in_instr,
    input  w, err, readnum, writenum, write, loada, loadb, loadc, loads, asel, bsel, vsel, sximm8
  );
endinterface

// File: rtl/regfile_sequencer.sv
// regfile_sequencer: Moore FSM sequencing regfile reads, ALU step and writeback per instruction.
module regfile_sequencer #(
  parameter int RN_W = 3,
  parameter int IW   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  regfile_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_RD_A, S_RD_B, S_EXEC, S_WR_C, S_WR_IMM, S_ERR
  } state_t;
  state_t        r_state, w_next;
  logic [IW-1:0] r_instr;
  logic [2:0]    w_opc;
  logic [1:0]    w_op;
  logic          w_movi, w_movr, w_alu, w_cmp, w_mvn;
  assign w_opc  = r_instr[15:13];
  assign w_op   = r_instr[12:11];
  assign w_movi = w_opc == 3'b110 && w_op == 2'b10;
  assign w_movr = w_opc == 3'b110 && w_op == 2'b00;
  assign w_alu  = w_opc == 3'b101;
  assign w_cmp  = w_alu && w_op == 2'b01;
  assign w_mvn  = w_alu && w_op == 2'b11;
  assign bus.sximm8 = {{(IW-8){r_instr[7]}}, r_instr[7:0]};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_instr <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && bus.s) r_instr <= bus.in_instr;
    end
  // outputs depend on state only; the latched instruction just supplies register numbers
  always_comb begin
    w_next       = r_state;
    bus.w        = 1'b0;
    bus.err      = 1'b0;
    bus.readnum  = '0;
    bus.writenum = '0;
    bus.write    = 1'b0;
    bus.loada    = 1'b0;
    bus.loadb    = 1'b0;
    bus.loadc    = 1'b0;
    bus.loads    = 1'b0;
    bus.asel     = 1'b0;
    bus.bsel     = 1'b0;
    bus.vsel     = 2'b00;
    case (r_state)
      S_IDLE: begin
        bus.w  = 1'b1;
        w_next = bus.s ? S_DECODE : S_IDLE;
      end
      S_DECODE: w_next = w_movi ? S_WR_IMM : (w_movr || w_mvn) ? S_RD_B : w_alu ? S_RD_A : S_ERR;
      S_RD_A: begin
        bus.readnum = r_instr[8 +: RN_W];
        bus.loada   = 1'b1;
        w_next      = S_RD_B;
      end
      S_RD_B: begin
        bus.readnum = r_instr[0 +: RN_W];
        bus.loadb   = 1'b1;
        w_next      = S_EXEC;
      end
      S_EXEC: begin
        bus.asel  = w_movr || w_mvn;
        bus.loads = w_cmp;
        bus.loadc = !w_cmp;
        w_next    = w_cmp ? S_IDLE : S_WR_C;
      end
      S_WR_C: begin
        bus.writenum = r_instr[5 +: RN_W];
        bus.write    = 1'b1;
        w_next       = S_IDLE;
      end
      S_WR_IMM: begin
        bus.writenum = r_instr[8 +: RN_W];
        bus.vsel     = 2'b10;
        bus.write    = 1'b1;
        w_next       = S_IDLE;
      end
      S_ERR: begin
        bus.err = 1'b1;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end
endmodule
